// File: rtl/raster_stamp_fetch.sv
// Purpose: writer side of the per-warp raster stamp store; gathers one stamp per active lane, writes them, answers the SFU.
// Latency: request handshake to rsp_valid is k+2 cycles (k = COLLECT cycles, 0 when the request mask is empty).
// Backpressure: one request in flight; req_ready only in IDLE, stamp_ready only in COLLECT, response held until rsp_ready.

package raster_stamp_pkg;
  typedef struct packed {
    logic [15:0]      pos_x;
    logic [15:0]      pos_y;
    logic [3:0]       mask;
    logic [2:0][11:0] bcoords;
  } raster_stamp_t;
endpackage

module raster_stamp_fetch
  import raster_stamp_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NUM_LANES   = 1,
  parameter int NUM_THREADS = 4,
  parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1,
  parameter int UUID_WIDTH  = 44,
  parameter int NW_WIDTH    = 2,
  parameter int XLEN        = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  // fetch request from the SFU
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [UUID_WIDTH-1:0]               req_uuid,
  input  logic [NW_WIDTH-1:0]                 req_wid,
  input  logic [NUM_LANES-1:0]                req_tmask,
  input  logic [PID_WIDTH-1:0]                req_pid,
  // stamp stream from the raster unit
  input  logic                                stamp_valid,
  output logic                                stamp_ready,
  input  raster_stamp_t                       stamp_data,
  input  logic                                stamp_done,
  // stamp store write port
  output logic                                write_enable,
  output logic [UUID_WIDTH-1:0]               write_uuid,
  output logic [NW_WIDTH-1:0]                 write_wid,
  output logic [NUM_LANES-1:0]                write_tmask,
  output logic [PID_WIDTH-1:0]                write_pid,
  output raster_stamp_t [NUM_LANES-1:0]       write_data,
  // response to the SFU
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [UUID_WIDTH-1:0]               rsp_uuid,
  output logic [NW_WIDTH-1:0]                 rsp_wid,
  output logic [PID_WIDTH-1:0]                rsp_pid,
  output logic [NUM_LANES-1:0]                rsp_tmask,
  output logic [NUM_LANES-1:0][XLEN-1:0]      rsp_data
);

  // CORE_ID only tags trace output; this empty guard marks configurations that make no sense.
  if (CORE_ID < 0 || NUM_LANES < 1) begin : g_bad_config
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_RSP} state_t;

  state_t                        state, state_next;
  logic [NUM_LANES-1:0]          remain_q, remain_d;
  logic [NUM_LANES-1:0]          collect_q, collect_d;
  logic [NUM_LANES-1:0]          lane_sel;
  logic                          idle_ready;
  logic [UUID_WIDTH-1:0]         uuid_q;
  logic [NW_WIDTH-1:0]           wid_q;
  logic [PID_WIDTH-1:0]          pid_q;
  logic [NUM_LANES-1:0]          tmask_q;
  raster_stamp_t [NUM_LANES-1:0] stamp_q;

  // One-hot of the lowest lane still waiting for a stamp.
  always_comb begin
    lane_sel = remain_q & (~remain_q + NUM_LANES'(1));
  end

  // Next-state, lane bookkeeping and handshake/strobe outputs.
  always_comb begin
    state_next   = state;
    remain_d     = remain_q;
    collect_d    = collect_q;
    idle_ready   = 1'b0;
    stamp_ready  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        idle_ready = 1'b1;
        if (req_valid) begin
          remain_d   = req_tmask;
          collect_d  = '0;
          state_next = (req_tmask == '0) ? S_WRITE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        stamp_ready = 1'b1;
        // A real stamp wins over done in the same cycle.
        if (stamp_valid) begin
          remain_d  = remain_q & ~lane_sel;
          collect_d = collect_q | lane_sel;
        end else if (stamp_done) begin
          remain_d = '0;
        end
        if (remain_d == '0) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        write_enable = (collect_q != '0);
        state_next   = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Gate with reset so the SFU never sees ready while the block is held in reset.
  assign req_ready = idle_ready & reset_n;

  // State and lane masks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remain_q  <= '0;
      collect_q <= '0;
    end else begin
      state     <= state_next;
      remain_q  <= remain_d;
      collect_q <= collect_d;
    end
  end

  // Latched request fields and collected stamps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uuid_q  <= '0;
      wid_q   <= '0;
      pid_q   <= '0;
      tmask_q <= '0;
      stamp_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        uuid_q  <= req_uuid;
        wid_q   <= req_wid;
        pid_q   <= req_pid;
        tmask_q <= req_tmask;
      end
      if (state == S_COLLECT && stamp_valid) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_sel[i]) begin
            stamp_q[i] <= stamp_data;
          end
        end
      end
    end
  end

  assign write_uuid  = uuid_q;
  assign write_wid   = wid_q;
  assign write_pid   = pid_q;
  assign write_tmask = collect_q;
  assign write_data  = stamp_q;

  assign rsp_uuid  = uuid_q;
  assign rsp_wid   = wid_q;
  assign rsp_pid   = pid_q;
  assign rsp_tmask = tmask_q;

  // Per-lane result: 1 when the lane received a stamp, 0 when the raster unit ran dry.
  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rsp_data[i] = XLEN'(collect_q[i]);
    end
  end

endmodule

// File: tb/tb_raster_stamp_fetch.sv
module tb_raster_stamp_fetch;
  import raster_stamp_pkg::*;

  localparam int NL  = 4;
  localparam int NT  = 16;
  localparam int PW  = 2;
  localparam int UW  = 16;
  localparam int NWW = 4;
  localparam int XL  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        reset_n;
  logic                        req_valid, req_ready;
  logic [UW-1:0]               req_uuid;
  logic [NWW-1:0]              req_wid;
  logic [NL-1:0]               req_tmask;
  logic [PW-1:0]               req_pid;
  logic                        stamp_valid, stamp_ready, stamp_done;
  raster_stamp_t               stamp_data;
  logic                        write_enable;
  logic [UW-1:0]               write_uuid;
  logic [NWW-1:0]              write_wid;
  logic [NL-1:0]               write_tmask;
  logic [PW-1:0]               write_pid;
  raster_stamp_t [NL-1:0]      write_data;
  logic                        rsp_valid, rsp_ready;
  logic [UW-1:0]               rsp_uuid;
  logic [NWW-1:0]              rsp_wid;
  logic [PW-1:0]               rsp_pid;
  logic [NL-1:0]               rsp_tmask;
  logic [NL-1:0][XL-1:0]       rsp_data;

  raster_stamp_fetch #(
    .CORE_ID(0), .NUM_LANES(NL), .NUM_THREADS(NT), .PID_WIDTH(PW),
    .UUID_WIDTH(UW), .NW_WIDTH(NWW), .XLEN(XL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_pid(req_pid),
    .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
    .stamp_data(stamp_data), .stamp_done(stamp_done),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
    .write_tmask(write_tmask), .write_pid(write_pid), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
    .rsp_wid(rsp_wid), .rsp_pid(rsp_pid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic raster_stamp_t rnd_stamp();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(raster_stamp_t)-1:0];
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-lane result words the SFU should see for a collected mask.
  function automatic logic [127:0] exp_rsp(input logic [NL-1:0] col);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*XL +: XL] = XL'(col[i]);
    return r;
  endfunction

  // One request end to end. ev holds scripted {valid,done} pairs per COLLECT cycle;
  // once they run out the stream is random, forced to done after 16 cycles.
  task automatic run_txn(input logic [NL-1:0] tm, input logic [NWW-1:0] wid,
                         input logic [PW-1:0] pid, input logic [15:0] ev,
                         input int nev, input int hold);
    int            lanes[$];
    logic [NL-1:0] col;
    raster_stamp_t exp_data [NL];
    logic [UW-1:0] uuid;
    int            cyc;
    logic          v, d;
    raster_stamp_t s;

    uuid = UW'($urandom());
    col  = '0;
    for (int i = 0; i < NL; i++) begin
      exp_data[i] = '0;
      if (tm[i]) lanes.push_back(i);
    end

    // IDLE: present request, with a stray stamp that must not be consumed.
    req_valid = 1'b1; req_tmask = tm; req_wid = wid; req_pid = pid; req_uuid = uuid;
    stamp_valid = 1'b1; stamp_done = 1'b0; stamp_data = rnd_stamp();
    #1;
    chk("idle_req_ready", 128'(req_ready), 128'(1'b1));
    chk("idle_stamp_ready", 128'(stamp_ready), 128'(1'b0));
    step();
    req_valid = 1'b0; req_tmask = NL'($urandom()); req_wid = NWW'($urandom()); req_uuid = UW'($urandom());

    // COLLECT: the model hands stamps to active lanes in ascending order.
    cyc = 0;
    while (lanes.size() > 0) begin
      if (cyc < nev) begin
        v = ev[2*cyc+1]; d = ev[2*cyc];
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = (cyc >= 16) || ($urandom_range(0, 7) == 0);
      end
      s = rnd_stamp();
      stamp_valid = v; stamp_done = d; stamp_data = s;
      #1;
      chk("collect_stamp_ready", 128'(stamp_ready), 128'(1'b1));
      chk("collect_req_ready", 128'(req_ready), 128'(1'b0));
      chk("collect_write_en", 128'(write_enable), 128'(1'b0));
      chk("collect_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      if (v) begin
        col[lanes[0]]      = 1'b1;
        exp_data[lanes[0]] = s;
        void'(lanes.pop_front());
      end else if (d) begin
        lanes.delete();
      end
      cyc++;
      step();
    end

    // WRITE: single strobe, stamps still offered but not taken.
    stamp_valid = 1'b1; stamp_done = 1'b0; stamp_data = rnd_stamp();
    #1;
    chk("write_en", 128'(write_enable), 128'(col != '0));
    chk("write_tmask", 128'(write_tmask), 128'(col));
    chk("write_wid", 128'(write_wid), 128'(wid));
    chk("write_pid", 128'(write_pid), 128'(pid));
    chk("write_uuid", 128'(write_uuid), 128'(uuid));
    for (int i = 0; i < NL; i++)
      if (col[i]) chk("write_data", 128'(write_data[i]), 128'(exp_data[i]));
    chk("write_stamp_ready", 128'(stamp_ready), 128'(1'b0));
    chk("write_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    step();

    // RSP: held stable under backpressure; a new request must wait.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_tmask = NL'($urandom());
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      #1;
      chk("rsp_valid", 128'(rsp_valid), 128'(1'b1));
      chk("rsp_data", 128'(rsp_data), exp_rsp(col));
      chk("rsp_tmask", 128'(rsp_tmask), 128'(tm));
      chk("rsp_wid", 128'(rsp_wid), 128'(wid));
      chk("rsp_pid", 128'(rsp_pid), 128'(pid));
      chk("rsp_uuid", 128'(rsp_uuid), 128'(uuid));
      chk("rsp_req_ready", 128'(req_ready), 128'(1'b0));
      chk("rsp_stamp_ready", 128'(stamp_ready), 128'(1'b0));
      chk("rsp_write_en", 128'(write_enable), 128'(1'b0));
      step();
    end
    rsp_ready = 1'b0; stamp_valid = 1'b0;
    #1;
    chk("back_idle_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("back_idle_req_ready", 128'(req_ready), 128'(1'b1));
    chk("back_idle_write_en", 128'(write_enable), 128'(1'b0));
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_uuid = '0; req_wid = '0; req_tmask = '0; req_pid = '0;
    stamp_valid = 1'b0; stamp_done = 1'b0; stamp_data = '0; rsp_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_req_ready", 128'(req_ready), 128'(1'b0));
    chk("rst_stamp_ready", 128'(stamp_ready), 128'(1'b0));
    chk("rst_write_en", 128'(write_enable), 128'(1'b0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("rst_write_tmask", 128'(write_tmask), 128'(0));
    chk("rst_rsp_data", 128'(rsp_data), 128'(0));
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 128'(req_ready), 128'(1'b1));
    step();

    // Lanes 0,1,3 with back-to-back stamps.
    run_txn(4'b1011, 4'd3, 2'd1, 16'b10_10_10, 3, 0);
    // One stamp then done resolves the rest at once.
    run_txn(4'b1111, 4'd5, 2'd2, 16'b01_10, 2, 0);
    // Empty mask: straight to WRITE with no strobe.
    run_txn(4'b0000, 4'd7, 2'd0, 16'b0, 0, 0);
    // valid and done together on lane 0, then the rest still collect.
    run_txn(4'b1111, 4'd1, 2'd3, 16'b10_10_10_11, 4, 0);
    // Response held back for five cycles.
    run_txn(4'b0110, 4'd9, 2'd1, 16'b10_10, 2, 5);

    // Randomised traffic.
    for (int t = 0; t < 40; t++)
      run_txn(NL'($urandom()), NWW'($urandom()), PW'($urandom()), 16'b0, 0, $urandom_range(0, 3));

    // Reset in the middle of collection after two stamps.
    req_valid = 1'b1; req_tmask = 4'b1111; req_wid = 4'd2; req_pid = 2'd1; req_uuid = 16'h1234;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stamp_valid = 1'b1; stamp_data = rnd_stamp();
      step();
    end
    stamp_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_req_ready", 128'(req_ready), 128'(1'b0));
    chk("midrst_stamp_ready", 128'(stamp_ready), 128'(1'b0));
    chk("midrst_write_en", 128'(write_enable), 128'(1'b0));
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("midrst_write_tmask", 128'(write_tmask), 128'(0));
    step();
    step();
    reset_n = 1'b1;
    stamp_valid = 1'b1; stamp_data = rnd_stamp();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("after_rst_write_en", 128'(write_enable), 128'(1'b0));
      chk("after_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("after_rst_req_ready", 128'(req_ready), 128'(1'b1));
      chk("after_rst_stamp_ready", 128'(stamp_ready), 128'(1'b0));
      step();
    end
    stamp_valid = 1'b0;

    // Block still works normally after the aborted request.
    run_txn(4'b1000, 4'd4, 2'd2, 16'b10, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
